// File: rtl/gpu_wb_prim_assembler_pkg.sv
// Shared GPU writeback definitions: opcodes, datapath widths and FSM states.
package gpu_wb_prim_assembler_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned REG_WIDTH    = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP            = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD            = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETCOLOR       = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = 8'h22;
  localparam logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = 8'h23;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } prim_state_e;

endpackage

// File: rtl/gpu_prim_fifo.sv
// Assembled-primitive queue; state updates on the falling clock edge.
module gpu_prim_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_en, pop_en;

  // Extra pointer MSB separates full from empty when the indices match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  // Gate the head with empty so the output reads zero out of reset.
  assign rdata   = empty ? '0 : mem[rptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(negedge clk) begin
    if (push_en) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_wb_prim_assembler.sv
// GPU writeback: retires scalar/CC results and assembles vertices into primitives.
module gpu_wb_prim_assembler
  import gpu_wb_prim_assembler_pkg::*;
#(
  parameter int unsigned NUM_VERT   = 3,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            I_CLOCK,
  input  logic                            I_RESET_N,
  input  logic                            I_LOCK,
  input  logic                            I_Valid,
  input  logic [OPCODE_WIDTH-1:0]         I_Opcode,
  input  logic                            I_StripMode,
  input  logic [3:0]                      I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]            I_DestValue,
  input  logic [2:0]                      I_CCValue,
  input  logic                            I_RegWEn,
  input  logic                            I_CCWEn,
  input  logic [2*COORD_W-1:0]            I_VertexXY,
  output logic                            O_Stall,
  output logic                            O_RegWEn,
  output logic                            O_CCWEn,
  output logic [3:0]                      O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]            O_WriteBackData,
  output logic [2:0]                      O_CCValue,
  output logic                            O_PrimValid,
  input  logic                            I_PrimReady,
  output logic [NUM_VERT*2*COORD_W-1:0]   O_PrimVerts,
  output logic [COLOR_W-1:0]              O_PrimColor,
  output logic [7:0]                      O_DropCount
);

  localparam int unsigned VERT_W = 2 * COORD_W;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PRIM_W = NUM_VERT * VERT_W + COLOR_W;

  prim_state_e          state_q, state_d;
  logic [CNT_W-1:0]     vcnt_q, vcnt_d;
  logic                 strip_q, strip_d;
  logic                 emitted_q, emitted_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [7:0]           drop_q, drop_d;
  logic [VERT_W-1:0]    vbuf_q [NUM_VERT-1];
  logic [VERT_W-1:0]    vbuf_d [NUM_VERT-1];

  logic                 is_vertex, is_color, is_begin, is_end;
  logic                 completing, accept, partial, drop_inc;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [NUM_VERT*VERT_W-1:0] push_verts;
  logic [PRIM_W-1:0]    fifo_rdata;

  assign is_vertex  = (I_Opcode == OP_SETVERTEX);
  assign is_color   = (I_Opcode == OP_SETCOLOR);
  assign is_begin   = (I_Opcode == OP_BEGINPRIMITIVE);
  assign is_end     = (I_Opcode == OP_ENDPRIMITIVE);
  assign completing = (state_q == StCollect) && (vcnt_q == CNT_W'(NUM_VERT - 1));
  assign O_Stall    = I_LOCK & I_Valid & is_vertex & completing & fifo_full;
  assign accept     = I_LOCK & I_Valid & ~O_Stall;
  // A strip that has emitted owns its retained vertices; nothing is lost on END.
  assign partial    = (vcnt_q != '0) && (!strip_q || !emitted_q);

  // Pack buffered vertices plus the incoming one, v0 in the LSBs.
  always_comb begin
    push_verts = '0;
    for (int i = 0; i < int'(NUM_VERT) - 1; i++) begin
      push_verts[i*VERT_W +: VERT_W] = vbuf_q[i];
    end
    push_verts[(NUM_VERT-1)*VERT_W +: VERT_W] = I_VertexXY;
  end

  // Primitive FSM next-state, vertex buffer, colour and drop accounting.
  always_comb begin
    state_d   = state_q;
    vcnt_d    = vcnt_q;
    strip_d   = strip_q;
    emitted_d = emitted_q;
    color_d   = color_q;
    drop_d    = drop_q;
    vbuf_d    = vbuf_q;
    push      = 1'b0;
    drop_inc  = 1'b0;

    if (accept) begin
      if (is_color) color_d = I_DestValue[COLOR_W-1:0];
      unique case (state_q)
        StIdle: begin
          if (is_begin) begin
            state_d   = StCollect;
            vcnt_d    = '0;
            strip_d   = I_StripMode;
            emitted_d = 1'b0;
          end
        end
        StCollect: begin
          if (is_begin) begin
            drop_inc  = partial;
            vcnt_d    = '0;
            strip_d   = I_StripMode;
            emitted_d = 1'b0;
          end else if (is_end) begin
            drop_inc = partial;
            state_d  = StIdle;
            vcnt_d   = '0;
          end else if (is_vertex) begin
            if (completing) begin
              push = 1'b1;
              if (strip_q) begin
                for (int i = 0; i < int'(NUM_VERT) - 2; i++) vbuf_d[i] = vbuf_q[i+1];
                vbuf_d[NUM_VERT-2] = I_VertexXY;
                emitted_d          = 1'b1;
              end else begin
                vcnt_d = '0;
              end
            end else begin
              for (int i = 0; i < int'(NUM_VERT) - 1; i++) begin
                if (vcnt_q == CNT_W'(i)) vbuf_d[i] = I_VertexXY;
              end
              vcnt_d = vcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Primitive FSM state register.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q   <= StIdle;
      vcnt_q    <= '0;
      strip_q   <= 1'b0;
      emitted_q <= 1'b0;
      color_q   <= '0;
      drop_q    <= '0;
      for (int i = 0; i < int'(NUM_VERT) - 1; i++) vbuf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vcnt_q    <= vcnt_d;
      strip_q   <= strip_d;
      emitted_q <= emitted_d;
      color_q   <= color_d;
      drop_q    <= drop_d;
      vbuf_q    <= vbuf_d;
    end
  end

  // Scalar/CC retirement; enables are single-cycle pulses per accepted instruction.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_RegWEn          <= 1'b0;
      O_CCWEn           <= 1'b0;
      O_WriteBackRegIdx <= '0;
      O_WriteBackData   <= '0;
      O_CCValue         <= '0;
    end else begin
      O_RegWEn <= accept & I_RegWEn;
      O_CCWEn  <= accept & I_CCWEn;
      if (accept) begin
        O_WriteBackRegIdx <= I_DestRegIdx;
        O_WriteBackData   <= I_DestValue;
        O_CCValue         <= I_CCValue;
      end
    end
  end

  assign pop         = O_PrimValid & I_PrimReady;
  assign O_PrimValid = ~fifo_empty;
  assign O_PrimVerts = fifo_rdata[NUM_VERT*VERT_W-1:0];
  assign O_PrimColor = fifo_rdata[PRIM_W-1 -: COLOR_W];
  assign O_DropCount = drop_q;

  gpu_prim_fifo #(
    .Width (PRIM_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (I_CLOCK),
    .rst_n (I_RESET_N),
    .push  (push),
    .pop   (pop),
    .wdata ({color_q, push_verts}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_gpu_wb_prim_assembler.sv
// Randomised + directed bench with a queue-based primitive model and scoreboard.
module tb_gpu_wb_prim_assembler;
  import gpu_wb_prim_assembler_pkg::*;

  localparam int NV = 3;
  localparam int CW = 10;
  localparam int COLW = 12;
  localparam int FD = 4;
  localparam int VW = 2 * CW;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    lock, valid, strip, rwe, cwe, ready;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [3:0]              idx;
  logic [REG_WIDTH-1:0]    data;
  logic [2:0]              cc;
  logic [VW-1:0]           xy;
  logic                    o_stall, o_rwe, o_cwe, o_pvalid;
  logic [3:0]              o_idx;
  logic [REG_WIDTH-1:0]    o_data;
  logic [2:0]              o_cc;
  logic [NV*VW-1:0]        o_verts;
  logic [COLW-1:0]         o_color;
  logic [7:0]              o_drop;

  gpu_wb_prim_assembler #(
    .NUM_VERT   (NV),
    .COORD_W    (CW),
    .COLOR_W    (COLW),
    .FIFO_DEPTH (FD)
  ) dut (
    .I_CLOCK           (clk),
    .I_RESET_N         (rst_n),
    .I_LOCK            (lock),
    .I_Valid           (valid),
    .I_Opcode          (opcode),
    .I_StripMode       (strip),
    .I_DestRegIdx      (idx),
    .I_DestValue       (data),
    .I_CCValue         (cc),
    .I_RegWEn          (rwe),
    .I_CCWEn           (cwe),
    .I_VertexXY        (xy),
    .O_Stall           (o_stall),
    .O_RegWEn          (o_rwe),
    .O_CCWEn           (o_cwe),
    .O_WriteBackRegIdx (o_idx),
    .O_WriteBackData   (o_data),
    .O_CCValue         (o_cc),
    .O_PrimValid       (o_pvalid),
    .I_PrimReady       (ready),
    .O_PrimVerts       (o_verts),
    .O_PrimColor       (o_color),
    .O_DropCount       (o_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV*VW-1:0] v;
    logic [COLW-1:0]  c;
  } prim_t;

  int errors = 0;
  int checks = 0;
  prim_t sb[$];
  // Reference model: vertices of the open primitive as a plain list.
  logic [VW-1:0]   mq[$];
  bit              m_inprim, m_strip, m_emitted;
  logic [COLW-1:0] m_color;
  int              m_drop;
  int              rdy_mode;  // 0 = never ready, 1 = always, 2 = random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_close();
    if (mq.size() > 0 && (!m_strip || !m_emitted) && m_drop < 255) m_drop++;
    mq.delete();
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    m_inprim = 0;
    m_strip = 0;
    m_emitted = 0;
    m_color = '0;
    m_drop = 0;
  endfunction

  // One clock of stimulus; returns whether the instruction was accepted.
  task automatic step(input logic l, input logic v, input logic [7:0] op, input logic s,
                      input logic [VW-1:0] p_xy, input logic [15:0] d, input logic [3:0] ix,
                      input logic rw, input logic cw, input logic [2:0] c, output bit acc);
    bit    pstall, pushed;
    prim_t p;
    @(posedge clk);
    #1;
    lock = l; valid = v; opcode = op; strip = s; xy = p_xy;
    data = d; idx = ix; rwe = rw; cwe = cw; cc = c;
    ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    pstall = l && v && op == OP_SETVERTEX && m_inprim && mq.size() == NV - 1 && sb.size() == FD;
    chk("stall", 64'(o_stall), 64'(pstall));
    acc = l && v && !pstall;
    pushed = 0;
    if (acc) begin
      case (op)
        OP_SETCOLOR: m_color = d[COLW-1:0];
        OP_BEGINPRIMITIVE: begin
          if (m_inprim) model_close();
          mq.delete();
          m_inprim = 1; m_strip = s; m_emitted = 0;
        end
        OP_ENDPRIMITIVE: if (m_inprim) begin
          model_close();
          m_inprim = 0;
        end
        OP_SETVERTEX: if (m_inprim) begin
          mq.push_back(p_xy);
          if (mq.size() == NV) begin
            for (int i = 0; i < NV; i++) p.v[i*VW +: VW] = mq[i];
            p.c = m_color;
            pushed = 1;
            if (m_strip) begin
              void'(mq.pop_front());
              m_emitted = 1;
            end else begin
              mq.delete();
            end
          end
        end
        default: ;
      endcase
    end
    @(negedge clk);
    #2;
    if (pushed) sb.push_back(p);
    chk("reg_wen", 64'(o_rwe), 64'(acc && rw));
    chk("cc_wen", 64'(o_cwe), 64'(acc && cw));
    if (acc) begin
      chk("wb_idx", 64'(o_idx), 64'(ix));
      chk("wb_data", 64'(o_data), 64'(d));
      chk("wb_cc", 64'(o_cc), 64'(c));
    end
    chk("drop_count", 64'(o_drop), 64'(m_drop));
  endtask

  task automatic issue(input logic [7:0] op, input logic s, input logic [VW-1:0] p_xy,
                       input logic [15:0] d);
    bit acc = 0;
    for (int n = 0; n < 64 && !acc; n++) step(1, 1, op, s, p_xy, d, 4'h0, 0, 0, 3'h0, acc);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic vtx(input int x, input int y);
    issue(OP_SETVERTEX, 0, {CW'(y), CW'(x)}, 16'h0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1, 0, OP_NOP, 0, '0, 16'h0, 4'h0, 0, 0, 3'h0, acc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rwe"}, 64'(o_rwe), 64'd0);
    chk({tag, "_cwe"}, 64'(o_cwe), 64'd0);
    chk({tag, "_idx"}, 64'(o_idx), 64'd0);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_cc"}, 64'(o_cc), 64'd0);
    chk({tag, "_pvalid"}, 64'(o_pvalid), 64'd0);
    chk({tag, "_verts"}, 64'(o_verts), 64'd0);
    chk({tag, "_color"}, 64'(o_color), 64'd0);
    chk({tag, "_drop"}, 64'(o_drop), 64'd0);
    chk({tag, "_stall"}, 64'(o_stall), 64'd0);
  endtask

  // Monitor: the FIFO head must always match the oldest expected primitive.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst_n === 1'b1) begin
        chk("prim_valid", 64'(o_pvalid), 64'(sb.size() > 0));
        if (o_pvalid && sb.size() > 0) begin
          chk("prim_verts", 64'(o_verts), 64'(sb[0].v));
          chk("prim_color", 64'(o_color), 64'(sb[0].c));
          if (ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    rst_n = 0; lock = 0; valid = 0; opcode = OP_NOP; strip = 0; xy = '0;
    data = '0; idx = '0; rwe = 0; cwe = 0; cc = '0; ready = 0;
    rdy_mode = 1;
    model_reset();
    #23;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1;

    // List primitive with colour.
    issue(OP_BEGINPRIMITIVE, 0, '0, 16'h0);
    issue(OP_SETCOLOR, 0, '0, 16'hFABC);
    vtx(1, 2); vtx(3, 4); vtx(5, 6);
    idle(3);

    // Strip: five vertices give three primitives.
    issue(OP_BEGINPRIMITIVE, 1, '0, 16'h0);
    for (int i = 0; i < 5; i++) vtx(10 + i, 20 + i);
    idle(4);

    // Fill the FIFO, then stall on the completing vertex.
    rdy_mode = 0;
    issue(OP_BEGINPRIMITIVE, 0, '0, 16'h0);
    for (int i = 0; i < 14; i++) vtx(100 + i, 200 + i);
    for (int i = 0; i < 3; i++) step(1, 1, OP_SETVERTEX, 0, {CW'(300), CW'(99)}, 16'h0, 4'h0, 0,
                                     0, 3'h0, acc);
    rdy_mode = 1;
    step(1, 1, OP_SETVERTEX, 0, {CW'(300), CW'(99)}, 16'h0, 4'h0, 0, 0, 3'h0, acc);
    rdy_mode = 0;
    vtx(99, 300);
    rdy_mode = 1;
    idle(8);

    // Scalar writeback gated by lock.
    step(0, 1, OP_ADD, 0, '0, 16'h1234, 4'd5, 1, 0, 3'h0, acc);
    step(0, 1, OP_ADD, 0, '0, 16'h1234, 4'd5, 1, 0, 3'h0, acc);
    step(1, 1, OP_ADD, 0, '0, 16'h1234, 4'd5, 1, 0, 3'h0, acc);

    // Random traffic.
    rdy_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] op;
      case ($urandom_range(0, 7))
        0: op = OP_ADD;
        1: op = OP_SETCOLOR;
        2: op = OP_BEGINPRIMITIVE;
        3: op = OP_ENDPRIMITIVE;
        default: op = OP_SETVERTEX;
      endcase
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 5) != 0), op,
           1'($urandom_range(0, 1)), VW'($urandom), 16'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), acc);
    end
    rdy_mode = 1;
    idle(8);

    // Reset mid-primitive with two primitives queued.
    rdy_mode = 0;
    issue(OP_BEGINPRIMITIVE, 0, '0, 16'h0);
    for (int i = 0; i < 8; i++) vtx(i, i + 1);
    @(posedge clk);
    #1;
    valid = 0;
    rst_n = 0;
    model_reset();
    #2;
    check_all_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1;
    rdy_mode = 1;
    idle(2);

    // Partial list primitives are counted, saturating at 255.
    for (int n = 0; n < 256; n++) begin
      issue(OP_BEGINPRIMITIVE, 0, '0, 16'h0);
      vtx(n, 1); vtx(n, 2);
      issue(OP_ENDPRIMITIVE, 0, '0, 16'h0);
    end
    chk("drop_saturated", 64'(o_drop), 64'd255);

    // Still assembling after saturation.
    issue(OP_BEGINPRIMITIVE, 0, '0, 16'h0);
    vtx(7, 8); vtx(9, 10); vtx(11, 12);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
